// File: rtl/cypher_seq_detector.sv
// Sliding-window cypher detector: accepts one digit per enabled cycle, keeps a saturating
// running sum, and flags matches of the last NUM_DIGITS digits against a latched cypher.
module cypher_seq_detector #(
    parameter int DIGIT_W    = 4,
    parameter int NUM_DIGITS = 4,
    parameter int SUM_W      = 8,
    parameter int CNT_W      = 4
) (
    input  logic                          clock,
    input  logic                          sl_res,
    input  logic                          sl_op,
    input  logic                          clr,
    input  logic                          mode,
    input  logic [NUM_DIGITS*DIGIT_W-1:0] cypher,
    input  logic [DIGIT_W-1:0]            num,
    output logic                          stop,
    output logic                          hit,
    output logic [SUM_W-1:0]              sum,
    output logic                          sat,
    output logic [CNT_W-1:0]              match_count
);

    localparam int WIN_W  = NUM_DIGITS * DIGIT_W;
    localparam int HIST_W = (NUM_DIGITS - 1) * DIGIT_W;
    localparam int FILL_W = $clog2(NUM_DIGITS + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state_reg;
    // Only the newest NUM_DIGITS-1 digits are kept; the oldest digit drops out on every shift.
    logic [HIST_W-1:0]   window_reg;
    logic [WIN_W-1:0]    cyph_reg;
    logic [FILL_W-1:0]   fill_reg;
    logic [SUM_W-1:0]    sum_reg;
    logic                sat_reg;
    logic [CNT_W-1:0]    cnt_reg;
    logic                stop_reg;
    logic                hit_reg;

    logic [WIN_W-1:0]    window_next;
    logic [WIN_W-1:0]    ref_cypher;
    logic [FILL_W-1:0]   fill_next;
    logic [SUM_W:0]      sum_wide;
    logic [NUM_DIGITS-1:0] digit_eq;
    logic                window_full;
    logic                accept;
    logic                match;

    assign window_next = {window_reg, num};
    // The first digit after reset compares against the live port, since the latch fills on that same edge.
    assign ref_cypher  = (state_reg == IDLE) ? cypher : cyph_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit_cmp
            assign digit_eq[gi] = (window_next[gi*DIGIT_W +: DIGIT_W] == ref_cypher[gi*DIGIT_W +: DIGIT_W]);
        end
    endgenerate

    assign window_full = ((int'(fill_reg) + 1) >= NUM_DIGITS);
    assign fill_next   = (fill_reg == FILL_W'(NUM_DIGITS)) ? fill_reg : fill_reg + 1'b1;
    assign sum_wide    = {1'b0, sum_reg} + {{(SUM_W + 1 - DIGIT_W){1'b0}}, num};
    assign accept      = sl_op && (state_reg != DONE);
    assign match       = accept && window_full && (&digit_eq);

    always_ff @(posedge clock) begin
        if (sl_res || clr) begin
            state_reg  <= IDLE;
            window_reg <= '0;
            cyph_reg   <= '0;
            fill_reg   <= '0;
            sum_reg    <= '0;
            sat_reg    <= 1'b0;
            cnt_reg    <= '0;
            stop_reg   <= 1'b0;
            hit_reg    <= 1'b0;
        end else begin
            hit_reg <= 1'b0;
            if (accept) begin
                window_reg <= window_next[HIST_W-1:0];
                fill_reg   <= fill_next;
                if (sum_wide[SUM_W]) begin
                    sum_reg <= '1;
                    sat_reg <= 1'b1;
                end else begin
                    sum_reg <= sum_wide[SUM_W-1:0];
                end
                if (state_reg == IDLE) begin
                    cyph_reg <= cypher;
                end
                state_reg <= RUN;
                if (match) begin
                    hit_reg <= 1'b1;
                    if (~&cnt_reg) begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                    if (!mode) begin
                        state_reg <= DONE;
                        stop_reg  <= 1'b1;
                    end
                end
            end
        end
    end

    assign stop        = stop_reg;
    assign hit         = hit_reg;
    assign sum         = sum_reg;
    assign sat         = sat_reg;
    assign match_count = cnt_reg;

endmodule

// File: tb/tb_cypher_seq_detector.sv
// Bench for cypher_seq_detector: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_cypher_seq_detector;

    localparam int W    = 4;
    localparam int N    = 4;
    localparam int MAXS = 255;
    localparam int MAXC = 15;

    logic             clock = 1'b0;
    logic             sl_res = 1'b0;
    logic             sl_op = 1'b0;
    logic             clr = 1'b0;
    logic             mode = 1'b0;
    logic [N*W-1:0]   cypher = '0;
    logic [W-1:0]     num = '0;
    logic             stop;
    logic             hit;
    logic [7:0]       sum;
    logic             sat;
    logic [3:0]       match_count;

    int total = 0;
    int bad   = 0;
    bit checking = 0;

    cypher_seq_detector #(.DIGIT_W(W), .NUM_DIGITS(N), .SUM_W(8), .CNT_W(4)) dut (
        .clock(clock), .sl_res(sl_res), .sl_op(sl_op), .clr(clr), .mode(mode),
        .cypher(cypher), .num(num), .stop(stop), .hit(hit), .sum(sum), .sat(sat),
        .match_count(match_count)
    );

    always #5 clock = ~clock;

    // Reference model: last N accepted digits, integer sum, match counter, halted flag.
    int q[$];
    int m_sum = 0;
    int m_cnt = 0;
    bit m_sat = 0;
    bit m_stop = 0;
    bit m_hit = 0;
    bit m_run = 0;
    int m_cyph = 0;

    always @(posedge clock) begin
        int val;
        if (sl_res || clr) begin
            q.delete();
            m_sum = 0; m_cnt = 0; m_sat = 0; m_stop = 0; m_hit = 0; m_run = 0;
        end else begin
            m_hit = 0;
            if (sl_op && !m_stop) begin
                if (!m_run) begin
                    m_cyph = int'(cypher);
                    m_run = 1;
                end
                q.push_back(int'(num));
                if (q.size() > N) void'(q.pop_front());
                if (q.size() == N) begin
                    val = 0;
                    foreach (q[i]) val = (val << W) | q[i];
                    if (val == m_cyph) begin
                        m_hit = 1;
                        if (m_cnt < MAXC) m_cnt++;
                        if (!mode) m_stop = 1;
                    end
                end
                if (m_sum + int'(num) > MAXS) begin
                    m_sat = 1;
                    m_sum = MAXS;
                end else begin
                    m_sum = m_sum + int'(num);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (checking) begin
            chk("model_stop",  32'(stop),        32'(m_stop));
            chk("model_hit",   32'(hit),         32'(m_hit));
            chk("model_sum",   32'(sum),         32'(m_sum));
            chk("model_sat",   32'(sat),         32'(m_sat));
            chk("model_count", 32'(match_count), 32'(m_cnt));
        end
    end

    // Drive one cycle from a negedge; returns at the next negedge with outputs updated.
    task automatic cyc(input logic r, input logic c, input logic op, input logic [W-1:0] d);
        sl_res = r; clr = c; sl_op = op; num = d;
        @(posedge clock);
        @(negedge clock);
        sl_res = 0; clr = 0; sl_op = 0;
    endtask

    task automatic feed(input logic [W-1:0] d);
        cyc(0, 0, 1, d);
    endtask

    initial begin
        @(negedge clock);
        cyc(1, 0, 0, 0);
        checking = 1;
        chk("reset_stop", 32'(stop), 0);
        chk("reset_hit", 32'(hit), 0);
        chk("reset_sum", 32'(sum), 0);
        chk("reset_sat", 32'(sat), 0);
        chk("reset_count", 32'(match_count), 0);

        // Halt mode
        cypher = 16'h2601; mode = 0;
        feed(1); feed(3); feed(2); feed(6); feed(0);
        chk("halt_stop_early", 32'(stop), 0);
        feed(1);
        chk("halt_stop", 32'(stop), 1);
        chk("halt_hit", 32'(hit), 1);
        chk("halt_sum", 32'(sum), 13);
        chk("halt_count", 32'(match_count), 1);
        feed(5);
        chk("halt_frozen_sum", 32'(sum), 13);
        chk("halt_hit_pulse", 32'(hit), 0);
        chk("halt_stop_held", 32'(stop), 1);

        // Count mode with overlap
        cyc(1, 0, 0, 0);
        cypher = 16'h1212; mode = 1;
        feed(1); feed(2); feed(1);
        chk("ovl_no_hit3", 32'(hit), 0);
        feed(2);
        chk("ovl_hit4", 32'(hit), 1);
        feed(1);
        chk("ovl_no_hit5", 32'(hit), 0);
        feed(2);
        chk("ovl_hit6", 32'(hit), 1);
        chk("ovl_count", 32'(match_count), 2);
        chk("ovl_stop", 32'(stop), 0);
        chk("ovl_sum", 32'(sum), 9);

        // Partial window with all-zero cypher, restarted via clr
        cyc(0, 1, 0, 0);
        cypher = 16'h0000; mode = 0;
        feed(0); feed(0); feed(0);
        chk("part_stop3", 32'(stop), 0);
        feed(0);
        chk("part_stop4", 32'(stop), 1);

        // Saturation
        cyc(1, 0, 0, 0);
        cypher = 16'h1234; mode = 1;
        for (int i = 0; i < 17; i++) feed(15);
        chk("sat17_sum", 32'(sum), 255);
        chk("sat17_sat", 32'(sat), 0);
        feed(15);
        chk("sat18_sum", 32'(sum), 255);
        chk("sat18_sat", 32'(sat), 1);

        // Reset mid-operation beats sl_op
        cyc(1, 0, 0, 0);
        cypher = 16'h2601; mode = 0;
        feed(2); feed(6);
        cyc(1, 0, 1, 0);
        chk("midrst_sum", 32'(sum), 0);
        chk("midrst_stop", 32'(stop), 0);
        chk("midrst_count", 32'(match_count), 0);
        feed(2); feed(6); feed(0); feed(1);
        chk("midrst_match_stop", 32'(stop), 1);
        chk("midrst_match_sum", 32'(sum), 9);

        // Gaps and cypher change after latch
        cyc(1, 0, 0, 0);
        cypher = 16'h2601; mode = 0;
        feed(2);
        cypher = 16'hFFFF;
        cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
        feed(6);
        cyc(0, 0, 0, 0);
        chk("gap_hold_hit", 32'(hit), 0);
        feed(0); feed(1);
        chk("gap_stop", 32'(stop), 1);
        chk("gap_sum", 32'(sum), 9);

        // Randomized traffic, small digit alphabet so matches actually occur
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 4000; i++) begin
            int r;
            logic [W-1:0] d;
            r = $urandom_range(0, 199);
            if (i % 60 == 0) begin
                for (int k = 0; k < N; k++) cypher[k*W +: W] = W'($urandom_range(0, 2));
            end
            if ($urandom_range(0, 19) == 0) mode = ~mode;
            if ($urandom_range(0, 9) == 0) d = W'($urandom_range(0, 15));
            else d = W'($urandom_range(0, 2));
            cyc(r == 0, r == 1, $urandom_range(0, 3) != 0, d);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cypher_seq_detector.md
Name: cypher_seq_detector

Overview:
- Parametrised successor of the cypher-detector datapath.
- Accepts one digit per enabled cycle and keeps a running saturating sum of accepted digits.
- Detects when the last NUM_DIGITS digits equal the programmed cypher, using a sliding window so overlapping matches are found.
- Two modes: halt on first match, or count every match while continuing to run. Sits between the digit-entry front end and the control FSM.

Parameters:
- DIGIT_W, 4, bit width of one digit.
- NUM_DIGITS, 4, digits in the cypher and in the window (>=2).
- SUM_W, 8, width of the running sum (>= DIGIT_W).
- CNT_W, 4, width of the match counter.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- sl_res  in  1  reset, synchronous, active-high.
- sl_op  in  1  digit-valid; num is accepted on the rising edge when high.
- clr  in  1  synchronous restart pulse; same effect as sl_res.
- mode  in  1  0 = halt on first match; 1 = count matches and continue.
- cypher  in  NUM_DIGITS*DIGIT_W  target sequence; the most-significant digit is entered first.
- num  in  DIGIT_W  incoming digit.
- stop  out  1  registered; high after a match in halt mode.
- hit  out  1  registered one-cycle pulse on each match (both modes).
- sum  out  SUM_W  registered saturating sum of accepted digits.
- sat  out  1  sticky; set once sum has saturated.
- match_count  out  CNT_W  number of matches, saturating at all-ones.

Behaviour:
- Reset: the clock is single; reset is synchronous, active-high, and sampled on the rising clock edge.
- sl_res or clr high:
  - state goes to IDLE;
  - window, fill count, sum, sat, match_count, stop and hit all go to 0.
  - This takes priority over sl_op in the same cycle and applies mid-operation.
- States: IDLE, RUN, DONE.
  - IDLE: with sl_op=1, latch cypher into cyph_q, accept the digit, go to RUN. The compare in this cycle uses the cypher port directly.
  - RUN: with sl_op=1, accept the digit. A match in mode 0 goes to DONE. A match in mode 1 stays in RUN.
  - DONE: stop=1. sl_op is ignored; window, sum and counters are frozen. Exit is only via sl_res or clr.
- Cypher changes after latching are ignored until the next IDLE.
- Accepting a digit:
  - window <= {window[(NUM_DIGITS-1)*DIGIT_W-1:0], num};
  - fill <= min(fill+1, NUM_DIGITS);
  - sum <= sum + num, clamped to 2^SUM_W-1;
  - sat <= 1 if the unclamped sum exceeds that value.
- Match condition, evaluated on the shifted window including the new digit:
  - (fill+1 >= NUM_DIGITS) and new_window == cypher (or cyph_q once latched).
  - No match can occur before NUM_DIGITS digits have been accepted since reset, even if the cypher is all zeros.
- Latency: one cycle. stop, hit, sum and match_count reflect the digit accepted on edge N just after edge N.
- On a match:
  - hit is high for exactly one cycle;
  - match_count increments, saturating at 2^CNT_W-1 with no wrap;
  - the matching digit is included in sum.
- Overlap: the window is not cleared after a match in mode 1. Consecutive overlapping matches on adjacent cycles each pulse hit.
- sl_op low in RUN: hold all state; hit=0.
- mode is sampled every cycle. Changing mode in RUN affects only subsequent matches.

Test Plan:
- Halt mode, cypher=0x2601, mode=0, digits 1,3,2,6,0,1 on consecutive cycles:
  - stop=1 and hit pulses one cycle after the 6th digit; sum=13, match_count=1.
  - A further digit 5 is ignored: sum stays 13.
- Count mode with overlap, cypher=0x1212, mode=1, digits 1,2,1,2,1,2:
  - hit after the 4th and 6th digits; match_count=2, stop=0, sum=9.
- Partial window, cypher=0x0000, mode=0, digits 0,0,0:
  - stop=0; after a 4th 0, stop=1.
- Saturation: 18 digits of 15 in mode 1 with no match (cypher=0x1234):
  - sum=255 and sat=1 after the 18th digit; sum=255 at the 17th (17*15=255) with sat still 0.
- Reset mid-operation, cypher=0x2601:
  - Feed 2,6; assert sl_res together with sl_op=1, num=0. All outputs are 0 next cycle, and the 0 is not accepted.
  - Then 2,6,0,1 gives stop after the 4th digit, sum=9.
- Gaps and cypher change: cypher=0x2601, digits 2,6 with idle cycles between them, and cypher changed to 0xFFFF after the first digit; then 0,1:
  - match and stop=1 (latched cypher used); sum=9.
